// File: rtl/seg7_pkg.sv
// Shared glyph set and code constants for the 7-segment display drivers.
// Segment vectors are active-high, bit order {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_L     = 4'hB;
  localparam logic [3:0] CODE_C     = 4'hC;
  localparam logic [3:0] CODE_R     = 4'hD;
  localparam logic [3:0] CODE_E     = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h01, 7'h0E, 7'h4E, 7'h46, 7'h4F, 7'h00
  };

  function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] code);
    return GLYPH[code];
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational 4-bit code to active-high segment pattern decoder.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0]       i_code,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = glyph_of(i_code);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered digit data,
// anti-ghost blanking and leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 1000,
  parameter int unsigned BLANK_CYCLES   = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_en,
  output logic [SEG_W-1:0]      seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int unsigned PCNT_W = $clog2(PRESCALE);
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS must be in 1..8");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg7_scan_driver: PRESCALE must be at least 2");
  end
  if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("seg7_scan_driver: BLANK_CYCLES must be below PRESCALE");
  end

  logic [PCNT_W-1:0]   r_pcnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp_data;
  logic [DIGITS-1:0]   r_disp_dp;
  logic                r_disp_lz;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_lz;
  logic                r_pending;
  logic                r_wrap_d;
  logic                r_frame_done;
  logic [SEG_W-1:0]    r_seg;
  logic                r_seg_dp;
  logic [DIGITS-1:0]   r_dig;

  logic                w_last_tick;
  logic                w_wrap;
  logic                w_apply;
  logic [DIGITS-1:0]   w_blank_mask;
  logic                w_seen_nz;
  logic [3:0]          w_cur_code;
  logic [3:0]          w_code;
  logic [SEG_W-1:0]    w_glyph;
  logic [DIGITS-1:0]   w_dig_onehot;

  assign w_last_tick = (r_pcnt == PCNT_LAST);
  assign w_wrap      = enable && w_last_tick && (r_idx == IDX_LAST);
  assign w_apply     = w_wrap || !enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (!enable) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_last_tick) begin
      r_pcnt <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // A load coinciding with an apply cycle bypasses the pending buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp_data <= '1;
      r_disp_dp   <= '0;
      r_disp_lz   <= 1'b0;
      r_pend_data <= '1;
      r_pend_dp   <= '0;
      r_pend_lz   <= 1'b0;
      r_pending   <= 1'b0;
    end else if (load && w_apply) begin
      r_disp_data <= data;
      r_disp_dp   <= dp;
      r_disp_lz   <= lz_en;
      r_pending   <= 1'b0;
    end else begin
      if (w_apply && r_pending) begin
        r_disp_data <= r_pend_data;
        r_disp_dp   <= r_pend_dp;
        r_disp_lz   <= r_pend_lz;
        r_pending   <= 1'b0;
      end
      if (load) begin
        r_pend_data <= data;
        r_pend_dp   <= dp;
        r_pend_lz   <= lz_en;
        r_pending   <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; digit 0 is never masked.
  always_comb begin
    w_blank_mask = '0;
    w_seen_nz    = 1'b0;
    for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
      if (r_disp_data[4*(DIGITS-1-i) +: 4] != 4'h0) begin
        w_seen_nz = 1'b1;
      end else if (r_disp_lz && !w_seen_nz) begin
        w_blank_mask[DIGITS-1-i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_cur_code = r_disp_data[4*r_idx +: 4];
    w_code     = w_blank_mask[r_idx] ? CODE_BLANK : w_cur_code;
  end

  always_comb begin
    w_dig_onehot        = '0;
    w_dig_onehot[r_idx] = 1'b1;
  end

  seg7_glyph u_glyph (
    .i_code (w_code),
    .o_seg  (w_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg    <= '0;
      r_seg_dp <= 1'b0;
      r_dig    <= '0;
    end else if (!enable || (r_pcnt < BLANK_END)) begin
      r_seg    <= '0;
      r_seg_dp <= 1'b0;
      r_dig    <= '0;
    end else begin
      r_seg    <= w_glyph;
      r_seg_dp <= r_disp_dp[r_idx];
      r_dig    <= w_dig_onehot;
    end
  end

  // Two-stage delay lines the pulse up with the first output of the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_d     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wrap_d     <= w_wrap;
      r_frame_done <= enable && r_wrap_d;
    end
  end

  assign seg        = r_seg ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign seg_dp     = r_seg_dp ^ SEG_ACTIVE_LOW;
  assign dig        = r_dig ^ {DIGITS{DIG_ACTIVE_LOW}};
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: 4 digits, 4-cycle slots, 1 blanking cycle; a second
// instance with inverted pin polarity shares all inputs.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lz_en;

  logic [6:0]  seg, seg_n;
  logic        seg_dp, seg_dp_n;
  logic [3:0]  dig, dig_n;
  logic        pending, pending_n;
  logic        frame_done, frame_done_n;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
    .dp(dp), .lz_en(lz_en), .seg(seg), .seg_dp(seg_dp), .dig(dig),
    .pending(pending), .frame_done(frame_done)
  );

  seg7_scan_driver #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data(data),
    .dp(dp), .lz_en(lz_en), .seg(seg_n), .seg_dp(seg_dp_n), .dig(dig_n),
    .pending(pending_n), .frame_done(frame_done_n)
  );

  int checks = 0;
  int errors = 0;
  int m = 0;

  logic [6:0] exp_g [4];
  logic [3:0] exp_dpv;
  logic       exp_pend;
  logic [6:0] gly_ref [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h01, 7'h0E, 7'h4E, 7'h46, 7'h4F, 7'h00
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s m=%0d observed=%0h expected=%0h", tag, m, obs, expv);
    end
  endtask

  task automatic chk_pins(input logic [6:0] es, input logic ed, input logic [3:0] eg,
                          input logic ef, input logic ep);
    logic [6:0] inv_s;
    logic [3:0] inv_g;
    logic       inv_d;
    inv_s = ~es;
    inv_g = ~eg;
    inv_d = ~ed;
    chk("seg", seg, es);
    chk("seg_dp", seg_dp, ed);
    chk("dig", dig, eg);
    chk("frame_done", frame_done, ef);
    chk("pending", pending, ep);
    chk("seg_inv", seg_n, inv_s);
    chk("seg_dp_inv", seg_dp_n, inv_d);
    chk("dig_inv", dig_n, inv_g);
    chk("frame_done_inv", frame_done_n, ef);
    chk("pending_inv", pending_n, ep);
  endtask

  // m counts edges since enable; edge m shows the slot state of cycle m-1.
  task automatic scan_tick();
    int ph;
    int sl;
    logic [6:0] es;
    logic       ed;
    logic [3:0] eg;
    logic       ef;
    @(posedge clk);
    #1;
    m++;
    ph = (m - 1) % 4;
    sl = ((m - 1) / 4) % 4;
    if (ph == 0) begin
      es = 7'h00; ed = 1'b0; eg = 4'b0000;
    end else begin
      es = exp_g[sl]; ed = exp_dpv[sl]; eg = 4'b0001 << sl;
    end
    ef = (m % 16 == 1) && (m > 1);
    chk_pins(es, ed, eg, ef, exp_pend);
  endtask

  task automatic dark_tick();
    @(posedge clk);
    #1;
    chk_pins(7'h00, 1'b0, 4'b0000, 1'b0, exp_pend);
  endtask

  task automatic boundary_load(input logic [15:0] d, input logic [3:0] p, input logic lz);
    while (m % 16 != 15) scan_tick();
    load = 1'b1; data = d; dp = p; lz_en = lz;
    scan_tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; data = '0; dp = '0; lz_en = 1'b0;
    exp_pend = 1'b0; exp_dpv = '0;
    for (int i = 0; i < 4; i++) exp_g[i] = 7'h00;

    #12;
    chk_pins(7'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load while disabled goes straight to display.
    load = 1'b1; data = 16'h1234; dp = 4'b0100; lz_en = 1'b0;
    dark_tick();
    load = 1'b0;
    dark_tick();

    enable = 1'b1; m = 0;
    exp_g[0] = 7'h33; exp_g[1] = 7'h79; exp_g[2] = 7'h6D; exp_g[3] = 7'h30;
    exp_dpv = 4'b0100;
    repeat (36) scan_tick();

    // Mid-frame load, then overwrite before the boundary.
    load = 1'b1; data = 16'h5678; dp = 4'b0000; exp_pend = 1'b1;
    scan_tick();
    load = 1'b0;
    repeat (3) scan_tick();
    load = 1'b1; data = 16'h9ABC; dp = 4'b0001;
    scan_tick();
    load = 1'b0;
    while (m != 47) scan_tick();
    exp_pend = 1'b0;
    scan_tick();
    exp_g[0] = 7'h4E; exp_g[1] = 7'h0E; exp_g[2] = 7'h01; exp_g[3] = 7'h7B;
    exp_dpv = 4'b0001;

    // Boundary loads with leading-zero suppression.
    boundary_load(16'h0050, 4'b0000, 1'b1);
    exp_g[0] = 7'h7E; exp_g[1] = 7'h5B; exp_g[2] = 7'h00; exp_g[3] = 7'h00;
    exp_dpv = 4'b0000;
    boundary_load(16'h0000, 4'b0000, 1'b1);
    exp_g[0] = 7'h7E; exp_g[1] = 7'h00; exp_g[2] = 7'h00; exp_g[3] = 7'h00;

    for (int c = 0; c < 16; c++) begin
      logic [15:0] d;
      d = 16'hFFF0 | 16'(c);
      boundary_load(d, 4'b0000, 1'b0);
      exp_g[0] = gly_ref[c]; exp_g[1] = 7'h00; exp_g[2] = 7'h00; exp_g[3] = 7'h00;
    end
    repeat (16) scan_tick();

    // Drop enable mid-slot while a digit is lit.
    while ((m - 1) % 4 != 2) scan_tick();
    enable = 1'b0;
    dark_tick();
    dark_tick();
    load = 1'b1; data = 16'h4321; dp = 4'b1000; lz_en = 1'b0;
    dark_tick();
    load = 1'b0;
    dark_tick();
    enable = 1'b1; m = 0;
    exp_g[0] = 7'h30; exp_g[1] = 7'h6D; exp_g[2] = 7'h79; exp_g[3] = 7'h33;
    exp_dpv = 4'b1000;
    repeat (22) scan_tick();

    // Pending update, then reset mid-slot discards it.
    load = 1'b1; data = 16'h1111; dp = 4'b1111; exp_pend = 1'b1;
    scan_tick();
    load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_pins(7'h00, 1'b0, 4'b0000, 1'b0, 1'b0);
    exp_pend = 1'b0;
    dark_tick();
    dark_tick();
    rst = 1'b0; m = 0;
    for (int i = 0; i < 4; i++) exp_g[i] = 7'h00;
    exp_dpv = 4'b0000;
    repeat (17) scan_tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
